// File: rtl/ysyx_2022040010_icache_refill_ctrl_if.sv
// AXI4 read-address and read-data channels between the icache refill controller and the arbiter.
// The master modport is the controller side; the slave modport is the arbiter or memory side.
interface ysyx_2022040010_icache_refill_ctrl_if;
    logic        arvalid;
    logic        arready;
    logic [63:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid;
    logic        rready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;

    modport master (
        output arvalid, araddr, arid, arlen, arsize, arburst, rready,
        input  arready, rvalid, rdata, rresp, rlast
    );

    modport slave (
        input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
        output arready, rvalid, rdata, rresp, rlast
    );
endinterface

// File: rtl/ysyx_2022040010_icache_refill_ctrl.sv
// Icache miss/refill sequencer: issues one AXI read per miss or uncached fetch, assembles the
// line and pulses refresh (or uc_valid) unless the fetch was flushed or the bus reported an error.
module ysyx_2022040010_icache_refill_ctrl #(
    parameter int unsigned LINE_BEATS = 2,
    parameter logic [3:0]  AXI_ID     = 4'd0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       miss,
    input  logic                       cache,
    input  logic                       uc_req,
    input  logic [63:0]                req_addr,
    input  logic                       lru,
    input  logic                       flush,
    output logic                       refresh,
    output logic [1:0]                 wr_way,
    output logic [64*LINE_BEATS-1:0]   line_data,
    output logic [63:0]                uc_data,
    output logic                       uc_valid,
    output logic                       busy,
    output logic                       bus_err,
    ysyx_2022040010_icache_refill_ctrl_if.master axi
);

    localparam int unsigned BeatW = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;

    typedef enum logic [1:0] {StIdle, StAr, StRdata, StDone} state_e;

    state_e                    state_q, state_d;
    logic [63:0]               araddr_q, araddr_d;
    logic [7:0]                arlen_q, arlen_d;
    logic                      kind_uc_q, kind_uc_d;
    logic                      victim_q, victim_d;
    logic [BeatW-1:0]          beat_q, beat_d;
    logic [64*LINE_BEATS-1:0]  line_q, line_d;
    logic                      squash_q, squash_d;
    logic                      err_q, err_d;
    logic                      last_by_count;

    // cache is implied by which request line is raised; low address bits are dropped by alignment.
    logic unused_ok;
    assign unused_ok = cache ^ (^req_addr[2:0]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            araddr_q  <= '0;
            arlen_q   <= '0;
            kind_uc_q <= 1'b0;
            victim_q  <= 1'b0;
            beat_q    <= '0;
            line_q    <= '0;
            squash_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            kind_uc_q <= kind_uc_d;
            victim_q  <= victim_d;
            beat_q    <= beat_d;
            line_q    <= line_d;
            squash_q  <= squash_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        araddr_d      = araddr_q;
        arlen_d       = arlen_q;
        kind_uc_d     = kind_uc_q;
        victim_d      = victim_q;
        beat_d        = beat_q;
        line_d        = line_q;
        squash_d      = squash_q;
        err_d         = err_q;
        last_by_count = 1'b0;
        refresh       = 1'b0;
        uc_valid      = 1'b0;
        bus_err       = 1'b0;
        axi.arvalid   = 1'b0;
        axi.rready    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (miss && !flush) begin
                    state_d   = StAr;
                    araddr_d  = {req_addr[63:4], 4'b0};
                    arlen_d   = 8'(LINE_BEATS - 1);
                    kind_uc_d = 1'b0;
                    victim_d  = lru;
                    squash_d  = 1'b0;
                    err_d     = 1'b0;
                end else if (uc_req && !flush) begin
                    state_d   = StAr;
                    araddr_d  = {req_addr[63:3], 3'b0};
                    arlen_d   = 8'd0;
                    kind_uc_d = 1'b1;
                    squash_d  = 1'b0;
                    err_d     = 1'b0;
                end
            end
            StAr: begin
                axi.arvalid = 1'b1;
                if (flush) squash_d = 1'b1;
                if (axi.arready) begin
                    state_d = StRdata;
                    beat_d  = '0;
                end
            end
            StRdata: begin
                axi.rready = 1'b1;
                if (flush) squash_d = 1'b1;
                if (axi.rvalid) begin
                    line_d[int'(beat_q)*64 +: 64] = axi.rdata;
                    beat_d        = beat_q + 1'b1;
                    last_by_count = kind_uc_q || (int'(beat_q) == LINE_BEATS - 1);
                    // rlast ends the burst; disagreement with the expected count is an error.
                    if ((axi.rresp != 2'b00) || (axi.rlast != last_by_count)) err_d = 1'b1;
                    if (axi.rlast || last_by_count) state_d = StDone;
                end
            end
            StDone: begin
                if (err_q) begin
                    bus_err = 1'b1;
                end else if (!squash_q && !flush) begin
                    if (kind_uc_q) uc_valid = 1'b1;
                    else           refresh  = 1'b1;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign wr_way      = refresh ? (victim_q ? 2'b10 : 2'b01) : 2'b00;
    assign line_data   = line_q;
    assign uc_data     = line_q[63:0];
    assign busy        = (state_q != StIdle);
    assign axi.araddr  = araddr_q;
    assign axi.arlen   = arlen_q;
    assign axi.arid    = AXI_ID;
    assign axi.arsize  = 3'b011;
    assign axi.arburst = 2'b01;

endmodule
